// File: rtl/multi_flow_traffic_generator.sv
// Multi-flow packet injection source feeding a PIFO-style sink.
// Each flow decides to inject either from an LFSR compared against its rate
// (random mode) or from the carry-out of a rate accumulator (deterministic mode).
// A round-robin arbiter moves one pending request per cycle into a registered
// output stage that holds its fields until the sink accepts them.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   i__generate_phase       injection window enable
//   i__mode                 0 = LFSR injection, 1 = accumulator injection
//   i__flow_enable          per-flow enable
//   i__injrate              per-flow rate, flow f at [f*RATE_BITS +: RATE_BITS]
//   i__total_packets        packet budget per flow
//   i__seed                 base seed for all LFSRs
//   i__pifo_ready           sink accepts the presented packet
//   o__valid                packet presented
//   o__packet_pointer       pointer of presented packet
//   o__packet_priority      priority of presented packet
//   o__flow_id              flow of presented packet
//   o__num_pkts_sent        accepted packets, all flows (saturating)
//   o__done                 every enabled flow hit its budget and nothing is in flight
module multi_flow_traffic_generator #(
  parameter int unsigned NUM_FLOWS = 4,
  parameter int unsigned PTR_BITS  = 16,
  parameter int unsigned PRIO_BITS = 16,
  parameter int unsigned RATE_BITS = 8,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i__generate_phase,
  input  logic                           i__mode,
  input  logic [NUM_FLOWS-1:0]           i__flow_enable,
  input  logic [NUM_FLOWS*RATE_BITS-1:0] i__injrate,
  input  logic [CNT_BITS-1:0]            i__total_packets,
  input  logic [PRIO_BITS-1:0]           i__seed,
  input  logic                           i__pifo_ready,
  output logic                           o__valid,
  output logic [PTR_BITS-1:0]            o__packet_pointer,
  output logic [PRIO_BITS-1:0]           o__packet_priority,
  output logic [$clog2(NUM_FLOWS)-1:0]   o__flow_id,
  output logic [CNT_BITS-1:0]            o__num_pkts_sent,
  output logic                           o__done
);

  localparam int unsigned FID_W = $clog2(NUM_FLOWS);

  // Maximal-length Fibonacci tap masks (bit n-1 set for tap n).
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      2:  lfsr_taps = 32'h0000_0003;
      3:  lfsr_taps = 32'h0000_0006;
      4:  lfsr_taps = 32'h0000_000C;
      5:  lfsr_taps = 32'h0000_0014;
      6:  lfsr_taps = 32'h0000_0030;
      7:  lfsr_taps = 32'h0000_0060;
      8:  lfsr_taps = 32'h0000_00B8;
      9:  lfsr_taps = 32'h0000_0110;
      10: lfsr_taps = 32'h0000_0240;
      11: lfsr_taps = 32'h0000_0500;
      12: lfsr_taps = 32'h0000_0829;
      13: lfsr_taps = 32'h0000_100D;
      14: lfsr_taps = 32'h0000_2015;
      15: lfsr_taps = 32'h0000_6000;
      16: lfsr_taps = 32'h0000_D008;
      17: lfsr_taps = 32'h0001_2000;
      18: lfsr_taps = 32'h0002_0400;
      19: lfsr_taps = 32'h0004_0023;
      20: lfsr_taps = 32'h0009_0000;
      21: lfsr_taps = 32'h0014_0000;
      22: lfsr_taps = 32'h0030_0000;
      23: lfsr_taps = 32'h0042_0000;
      24: lfsr_taps = 32'h00E1_0000;
      25: lfsr_taps = 32'h0120_0000;
      26: lfsr_taps = 32'h0200_0023;
      27: lfsr_taps = 32'h0400_0013;
      28: lfsr_taps = 32'h0900_0000;
      29: lfsr_taps = 32'h1400_0000;
      30: lfsr_taps = 32'h2000_0029;
      31: lfsr_taps = 32'h4800_0000;
      32: lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_0003;
    endcase
  endfunction

  // One left-shift step; feedback is the parity of the tapped bits.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v, input int unsigned w);
    logic [31:0] m;
    logic        fb;
    m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    fb = ^(v & lfsr_taps(w));
    lfsr_step = ((v << 1) | 32'(fb)) & m;
  endfunction

  // Per-flow state
  logic [RATE_BITS-1:0] inj_lfsr_q [NUM_FLOWS];
  logic [RATE_BITS-1:0] inj_lfsr_d [NUM_FLOWS];
  logic [RATE_BITS-1:0] inj_seed   [NUM_FLOWS];
  logic [RATE_BITS-1:0] acc_q      [NUM_FLOWS];
  logic [RATE_BITS-1:0] acc_d      [NUM_FLOWS];
  logic [RATE_BITS-1:0] rate_w     [NUM_FLOWS];
  logic [RATE_BITS:0]   acc_sum    [NUM_FLOWS];
  logic [CNT_BITS-1:0]  sent_q     [NUM_FLOWS];
  logic [CNT_BITS-1:0]  sent_d     [NUM_FLOWS];
  logic [CNT_BITS-1:0]  issued_q   [NUM_FLOWS];
  logic [CNT_BITS-1:0]  issued_d   [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] pending_q, pending_d;
  logic [NUM_FLOWS-1:0] elig, hit, req;

  // Shared output-side state
  logic [FID_W-1:0]     rr_q, rr_d, grant, arb_idx;
  logic                 grant_vld, load, xfer, all_met;
  logic [PRIO_BITS-1:0] prio_lfsr_q, prio_lfsr_d, prio_seed, seed_rev;
  logic [PTR_BITS-1:0]  ptr_lfsr_q, ptr_lfsr_d, ptr_seed;
  logic                 valid_q, valid_d, done_q, done_d;
  logic [FID_W-1:0]     fid_q, fid_d;
  logic [PTR_BITS-1:0]  ptr_q, ptr_d;
  logic [PRIO_BITS-1:0] prio_q, prio_d;
  logic [CNT_BITS-1:0]  num_q, num_d;

  // Seed derivation; an all-zero LFSR would lock up, so zero becomes 1.
  always_comb begin
    seed_rev = '0;
    for (int i = 0; i < PRIO_BITS; i++) seed_rev[i] = i__seed[PRIO_BITS-1-i];
    prio_seed = (i__seed == '0) ? PRIO_BITS'(1) : i__seed;
    ptr_seed  = PTR_BITS'(seed_rev);
    if (ptr_seed == '0) ptr_seed = PTR_BITS'(1);
    for (int f = 0; f < NUM_FLOWS; f++) begin
      inj_seed[f] = i__seed[RATE_BITS-1:0] ^ RATE_BITS'(f);
      if (inj_seed[f] == '0) inj_seed[f] = RATE_BITS'(1);
    end
  end

  assign load = !valid_q || i__pifo_ready;
  assign xfer = valid_q && i__pifo_ready;

  // Round-robin search starting at rr_q; index wraps because NUM_FLOWS is 2^k.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      arb_idx = rr_q + FID_W'(i);
      if (!grant_vld && pending_q[arb_idx]) begin
        grant     = arb_idx;
        grant_vld = 1'b1;
      end
    end
  end

  // Per-flow request generation and counters.
  always_comb begin
    for (int f = 0; f < NUM_FLOWS; f++) begin
      rate_w[f]  = i__injrate[f*RATE_BITS +: RATE_BITS];
      acc_sum[f] = {1'b0, acc_q[f]} + {1'b0, rate_w[f]};
      // pending_q gating also keeps a just-granted flow from re-requesting this cycle
      elig[f]    = i__generate_phase && i__flow_enable[f] && !pending_q[f] &&
                   (issued_q[f] < i__total_packets);
      hit[f]     = i__mode ? acc_sum[f][RATE_BITS] : (inj_lfsr_q[f] < rate_w[f]);
      req[f]     = elig[f] && hit[f];

      acc_d[f]      = (i__generate_phase && i__mode) ? acc_sum[f][RATE_BITS-1:0] : acc_q[f];
      inj_lfsr_d[f] = i__generate_phase ?
                      RATE_BITS'(lfsr_step(32'(inj_lfsr_q[f]), RATE_BITS)) : inj_lfsr_q[f];
      issued_d[f]   = req[f] ? issued_q[f] + CNT_BITS'(1) : issued_q[f];
      pending_d[f]  = (pending_q[f] && !(load && grant_vld && grant == FID_W'(f))) || req[f];
      sent_d[f]     = (xfer && fid_q == FID_W'(f) && sent_q[f] != '1) ?
                      sent_q[f] + CNT_BITS'(1) : sent_q[f];
    end
  end

  // Output stage, shared LFSRs, completion flag.
  always_comb begin
    valid_d     = valid_q;
    fid_d       = fid_q;
    ptr_d       = ptr_q;
    prio_d      = prio_q;
    rr_d        = rr_q;
    ptr_lfsr_d  = ptr_lfsr_q;
    prio_lfsr_d = prio_lfsr_q;
    if (load) begin
      valid_d = grant_vld;
      if (grant_vld) begin
        fid_d       = grant;
        ptr_d       = ptr_lfsr_q;
        prio_d      = prio_lfsr_q;
        ptr_lfsr_d  = PTR_BITS'(lfsr_step(32'(ptr_lfsr_q), PTR_BITS));
        prio_lfsr_d = PRIO_BITS'(lfsr_step(32'(prio_lfsr_q), PRIO_BITS));
        rr_d        = grant + FID_W'(1);
      end
    end
    num_d = (xfer && num_q != '1) ? num_q + CNT_BITS'(1) : num_q;

    all_met = 1'b1;
    for (int f = 0; f < NUM_FLOWS; f++) begin
      if (i__flow_enable[f] && (issued_q[f] < i__total_packets)) all_met = 1'b0;
    end
    done_d = all_met && (pending_q == '0) && !valid_q;
  end

  // LFSRs reload from the live seed during reset so a restarted run replays exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        inj_lfsr_q[f] <= inj_seed[f];
        acc_q[f]      <= '0;
        sent_q[f]     <= '0;
        issued_q[f]   <= '0;
      end
      pending_q   <= '0;
      rr_q        <= '0;
      ptr_lfsr_q  <= ptr_seed;
      prio_lfsr_q <= prio_seed;
      valid_q     <= 1'b0;
      fid_q       <= '0;
      ptr_q       <= '0;
      prio_q      <= '0;
      num_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        inj_lfsr_q[f] <= inj_lfsr_d[f];
        acc_q[f]      <= acc_d[f];
        sent_q[f]     <= sent_d[f];
        issued_q[f]   <= issued_d[f];
      end
      pending_q   <= pending_d;
      rr_q        <= rr_d;
      ptr_lfsr_q  <= ptr_lfsr_d;
      prio_lfsr_q <= prio_lfsr_d;
      valid_q     <= valid_d;
      fid_q       <= fid_d;
      ptr_q       <= ptr_d;
      prio_q      <= prio_d;
      num_q       <= num_d;
      done_q      <= done_d;
    end
  end

  assign o__valid           = valid_q;
  assign o__flow_id         = fid_q;
  assign o__packet_pointer  = ptr_q;
  assign o__packet_priority = prio_q;
  assign o__num_pkts_sent   = num_q;
  assign o__done            = done_q;

endmodule

// File: doc/multi_flow_traffic_generator.md
MULTI_FLOW_TRAFFIC_GENERATOR -- requirements
Module: multi_flow_traffic_generator

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- NUM_FLOWS, 4: independent traffic flows; power of two, 2..16.
- PTR_BITS, 16: packet pointer width.
- PRIO_BITS, 16: priority width.
- RATE_BITS, 8: injection rate, LFSR and accumulator width.
- CNT_BITS, 32: packet counter width.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- i__generate_phase, in, 1: injection window enable.
- i__mode, in, 1: 0 = random (LFSR) injection; 1 = deterministic (accumulator) injection.
- i__flow_enable, in, NUM_FLOWS: per-flow enable.
- i__injrate, in, NUM_FLOWS*RATE_BITS: per-flow rate; flow f occupies bits [f*RATE_BITS +: RATE_BITS].
- i__total_packets, in, CNT_BITS: packet budget per flow.
- i__seed, in, PRIO_BITS: base seed.
- i__pifo_ready, in, 1: downstream accepts the output.
- o__valid, out, 1: output packet valid.
- o__packet_pointer, out, PTR_BITS: pointer of the presented packet.
- o__packet_priority, out, PRIO_BITS: priority of the presented packet.
- o__flow_id, out, log2(NUM_FLOWS): flow of the presented packet.
- o__num_pkts_sent, out, CNT_BITS: total accepted packets, all flows.
- o__done, out, 1: all enabled flows have exhausted their budget and nothing is pending.
- Config inputs SHALL be held stable while i__generate_phase=1.

Function
REQ-003 Transfer SHALL occur on cycles where o__valid=1 and i__pifo_ready=1. While o__valid=1 and no transfer occurs, the output fields SHALL hold stable.
REQ-004 Each flow SHALL have the following state:
- a RATE_BITS injection LFSR;
- a RATE_BITS accumulator;
- a CNT_BITS sent counter;
- a CNT_BITS issued counter;
- a 1-bit pending flag.
REQ-005 Flow f is eligible when all of these hold: i__generate_phase=1, i__flow_enable[f]=1, pending[f]=0, and issued[f] < i__total_packets.
REQ-006 The injection LFSR SHALL step every cycle in which i__generate_phase=1. It is a maximal-length Fibonacci LFSR; its reset seed is i__seed[RATE_BITS-1:0] XOR f, and a zero seed is replaced by 1.
REQ-007 In random mode, an eligible flow SHALL set pending[f] and increment issued[f] in the same cycle when its LFSR value < rate[f].
REQ-008 In deterministic mode, the accumulator SHALL add rate[f] modulo 2^RATE_BITS each generate-phase cycle. An eligible flow SHALL request on the cycle the addition carries out. rate=0 never requests; rate=2^RATE_BITS-1 requests on 255 of 256 cycles at RATE_BITS=8.
REQ-009 A round-robin arbiter SHALL select among pending flows when o__valid=0 or a transfer occurs this cycle.
- The search starts at the flow after the last granted flow.
- After reset, the pointer starts at flow 0.
- The selected flow's pending flag clears and the output register loads next cycle, giving one-cycle request-to-o__valid latency.
- Back-to-back transfers SHALL sustain one packet per cycle.
REQ-010 o__packet_priority and o__packet_pointer SHALL come from shared PRIO_BITS and PTR_BITS LFSRs. These are seeded from i__seed and i__seed bit-reversed (zero replaced by 1), and SHALL step only on output-register load.
REQ-011 On a transfer, sent[flow_id] and o__num_pkts_sent SHALL increment by 1. Counters SHALL saturate at all-ones and never wrap.
REQ-012 If a flow becomes eligible in the same cycle its pending flag clears, it SHALL NOT set pending until the following cycle.
REQ-013 Deasserting i__generate_phase SHALL stop new requests only. Pending flags and o__valid SHALL drain normally.
REQ-014 Deasserting i__flow_enable[f] SHALL block new requests for f only; an existing pending[f] still drains.
REQ-015 o__done SHALL be registered, and asserts when both of these hold: issued[f] >= i__total_packets for every enabled flow, and no pending flag or o__valid is set. With i__total_packets=0, o__done SHALL assert one cycle after reset release.

Reset
REQ-016 While reset=0, asynchronously:
- o__valid=0, o__done=0, o__num_pkts_sent=0, o__flow_id=0, o__packet_pointer=0, o__packet_priority=0;
- all counters, pending flags and accumulators = 0;
- round-robin pointer = flow 0;
- LFSRs loaded with their seeds.
REQ-017 Reset asserted mid-transfer SHALL drop the in-flight packet with no counter update. The first post-reset packet SHALL reproduce the first packet of a fresh run with the same seeds.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Mode 1, NUM_FLOWS=4, rates {128,0,0,0}, budget 4, ready=1 -> flow 0 packets exactly every 2 cycles; o__num_pkts_sent=4; then o__done=1.
- Mode 1, all rates 255, ready=1, budget 3 -> o__flow_id sequence 0,1,2,3,0,1,2,3,0,1,2,3; 12 packets; o__done=1.
- Output valid with ready held 0 for 5 cycles -> pointer, priority and flow_id stable; no counter change; first ready=1 cycle transfers exactly once.
- Mode 0, seed 0x0001, rates all 0 -> o__valid never asserts; o__done stays 0 with budget 10.
- Reset asserted while o__valid=1 then released -> outputs 0, then the packet sequence matches the first run bit-for-bit.
- i__flow_enable=4'b0101 -> only flow ids 0 and 2 appear; o__done when flows 0 and 2 reach budget.
